// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator core: key codes, pending
// operator encoding, controller states and key classification helpers.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_CLR   = 4'hE;
  localparam logic [3:0] KEY_EQ    = 4'hF;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_DIGIT,
    ST_SHOW_ARG,
    ST_CALC,
    ST_DIV_WAIT,
    ST_SHOW_RES
  } state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // Operator keys map onto the op they leave pending; '=' leaves none.
  function automatic op_t key_to_op(input logic [3:0] key);
    case (key)
      KEY_PLUS:  return OP_ADD;
      KEY_MINUS: return OP_SUB;
      KEY_MUL:   return OP_MUL;
      KEY_DIV:   return OP_DIV;
      default:   return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, WIDTH clocks per
// division. start loads the operands; done is high during the cycle whose
// closing edge retires the last bit, so quotient is final right after it.
module calc_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction of the divisor from the partial remainder shifted left
  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign done     = run && (cnt == CW'(WIDTH - 1));
  assign quotient = quot;

  // Iteration state: remainder, dividend/quotient shift register, bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quot <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quot <= dividend;
      dvs  <= divisor;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      if (!diff[WIDTH]) begin
        rem  <= diff[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b1};
      end else begin
        rem  <= shifted[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Four-function keypad calculator core. Takes one decoded key per handshake
// while idle, builds the operand digit by digit, applies the pending operator
// on each operator/equals key and shows either the operand or the result.
// Division is delegated to a sequential divider when DIV_EN is set.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  parameter int DIV_EN     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] display,
  output logic             busy,
  output logic             ovf,
  output logic             err
);

  localparam int NDW = $clog2(MAX_DIGITS + 1);

  state_t           state;
  state_t           state_next;
  op_t              op;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] acc;
  logic [NDW-1:0]   ndig;
  logic [3:0]       key_hold;
  logic             eq_res;
  logic             div_pend;
  logic             chain;
  logic             div_go;
  logic             div_done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   dig_res;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic [WIDTH:0]   mul_res;

  // Each helper returns {overflow, low WIDTH bits of the true result}.
  function automatic logic [WIDTH:0] append_digit(input logic [WIDTH-1:0] a,
                                                  input logic [3:0]       d);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * (2*WIDTH)'(10) + (2*WIDTH)'(d);
    return {|full[2*WIDTH-1:WIDTH], full[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Bit WIDTH of the extended difference is the borrow.
  function automatic logic [WIDTH:0] sub_wrap(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [WIDTH:0] mul_wrap(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return {|full[2*WIDTH-1:WIDTH], full[WIDTH-1:0]};
  endfunction

  // Candidate results and the chaining/divide decisions for the current state
  always_comb begin
    dig_res = append_digit(arg, key_hold);
    add_res = add_wrap(acc, arg);
    sub_res = sub_wrap(acc, arg);
    mul_res = mul_wrap(acc, arg);
    // No operand typed since the last operator: the new operator just replaces it.
    chain   = (ndig == '0) && (op != OP_NONE);
    div_go  = (state == ST_CALC) && !chain && (op == OP_DIV) && (arg != '0);
  end

  if (DIV_EN != 0) begin : g_div
    calc_seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_go),
      .dividend (acc),
      .divisor  (arg),
      .done     (div_done),
      .quotient (quot)
    );
  end else begin : g_no_div
    assign div_done = 1'b0;
    assign quot     = '0;
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next = state;
    key_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    case (state)
      ST_CLEAR:    state_next = ST_IDLE;
      ST_IDLE: begin
        if (key_valid) begin
          if (is_digit(key_code))                        state_next = ST_DIGIT;
          else if (key_code == KEY_CLR)                  state_next = ST_CLEAR;
          else if ((key_code == KEY_DIV) && (DIV_EN == 0)) state_next = ST_IDLE;
          else                                           state_next = ST_CALC;
        end
      end
      ST_DIGIT:    state_next = ST_SHOW_ARG;
      ST_SHOW_ARG: state_next = ST_IDLE;
      ST_CALC:     state_next = div_go ? ST_DIV_WAIT : ST_SHOW_RES;
      ST_DIV_WAIT: if (div_done) state_next = ST_SHOW_RES;
      ST_SHOW_RES: state_next = ST_IDLE;
      default:     state_next = ST_CLEAR;
    endcase
  end

  // Operand/accumulator datapath, sticky flags and display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arg      <= '0;
      acc      <= '0;
      op       <= OP_NONE;
      ndig     <= '0;
      key_hold <= '0;
      eq_res   <= 1'b0;
      div_pend <= 1'b0;
      display  <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          arg      <= '0;
          acc      <= '0;
          op       <= OP_NONE;
          ndig     <= '0;
          eq_res   <= 1'b0;
          div_pend <= 1'b0;
          display  <= '0;
          ovf      <= 1'b0;
          err      <= 1'b0;
        end
        ST_IDLE: begin
          if (key_valid) key_hold <= key_code;
        end
        ST_DIGIT: begin
          if (ndig < NDW'(MAX_DIGITS)) begin
            arg  <= dig_res[WIDTH-1:0];
            ovf  <= ovf | dig_res[WIDTH];
            ndig <= ndig + NDW'(1);
          end
          // Typing after '=' starts a fresh calculation.
          if ((op == OP_NONE) && eq_res) begin
            acc    <= '0;
            eq_res <= 1'b0;
          end
        end
        ST_SHOW_ARG: display <= arg;
        ST_CALC: begin
          if (!chain) begin
            case (op)
              OP_NONE, OP_ADD: begin
                acc <= add_res[WIDTH-1:0];
                ovf <= ovf | add_res[WIDTH];
              end
              OP_SUB: begin
                acc <= sub_res[WIDTH-1:0];
                ovf <= ovf | sub_res[WIDTH];
              end
              OP_MUL: begin
                acc <= mul_res[WIDTH-1:0];
                ovf <= ovf | mul_res[WIDTH];
              end
              OP_DIV: begin
                if (arg == '0) begin
                  acc <= '1;
                  err <= 1'b1;
                end else begin
                  div_pend <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          op     <= key_to_op(key_hold);
          eq_res <= (key_hold == KEY_EQ);
          arg    <= '0;
          ndig   <= '0;
        end
        ST_SHOW_RES: begin
          if (div_pend) begin
            acc      <= quot;
            display  <= quot;
            div_pend <= 1'b0;
          end else begin
            display  <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine (WIDTH=16, MAX_DIGITS=4, DIV_EN=1).
// The stimulus process queues the expected display/flags/latency of every
// key it sends; the monitor checks them each time key_ready rises.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic             key_ready;
  logic [WIDTH-1:0] display;
  logic             busy;
  logic             ovf;
  logic             err;

  calc_engine #(.WIDTH(WIDTH), .MAX_DIGITS(4), .DIV_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .display   (display),
    .busy      (busy),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    disp;
    int    ovf;
    int    err;
    int    lat;
    int    acc_cyc;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input string tag, input int d, input int o, input int e,
                          input int lat, input int acc_cyc);
    exp_t item;
    item.disp    = d;
    item.ovf     = o;
    item.err     = e;
    item.lat     = lat;
    item.acc_cyc = acc_cyc;
    item.tag     = tag;
    sb.push_back(item);
  endtask

  // Present one key once the engine is ready; the accept edge is the next posedge.
  task automatic send(input string tag, input logic [3:0] k, input int d, input int o,
                      input int e, input int lat, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got key_ready=0, required 1", tag);
      return;
    end
    if (track) push_exp(tag, d, o, e, lat, cyc + 1);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  // Monitor: every rising key_ready completes the oldest outstanding key
  bit   prev_ready = 1'b0;
  exp_t mon_item;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && key_ready && !prev_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got display=%0d, required no response", display);
        end else begin
          mon_item = sb.pop_front();
          check({mon_item.tag, "_display"}, int'(display), mon_item.disp);
          check({mon_item.tag, "_ovf"}, int'(ovf), mon_item.ovf);
          check({mon_item.tag, "_err"}, int'(err), mon_item.err);
          check({mon_item.tag, "_latency"}, cyc - mon_item.acc_cyc, mon_item.lat);
          check({mon_item.tag, "_busy"}, int'(busy), 0);
        end
      end
      prev_ready = key_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_display", int'(display), 0);
    check("rst_key_ready", int'(key_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    push_exp("rst_release", 0, 0, 0, 1, cyc);

    // 1 2 + 3 4 =
    send("a_1",    4'd1,     1,  0, 0, 2, 1'b1);
    send("a_2",    4'd2,     12, 0, 0, 2, 1'b1);
    send("a_plus", KEY_PLUS, 12, 0, 0, 2, 1'b1);
    send("a_3",    4'd3,     3,  0, 0, 2, 1'b1);
    send("a_4",    4'd4,     34, 0, 0, 2, 1'b1);
    send("a_eq",   KEY_EQ,   46, 0, 0, 2, 1'b1);

    // 7 - 9 = borrows, then clear
    send("b_7",     4'd7,      7,     0, 0, 2, 1'b1);
    send("b_minus", KEY_MINUS, 7,     0, 0, 2, 1'b1);
    send("b_9",     4'd9,      9,     0, 0, 2, 1'b1);
    send("b_eq",    KEY_EQ,    65534, 1, 0, 2, 1'b1);
    send("b_clr",   KEY_CLR,   0,     0, 0, 1, 1'b1);

    // fifth digit ignored but still handshaken
    send("c_1",   4'd1,    1,    0, 0, 2, 1'b1);
    send("c_2",   4'd2,    12,   0, 0, 2, 1'b1);
    send("c_3",   4'd3,    123,  0, 0, 2, 1'b1);
    send("c_4",   4'd4,    1234, 0, 0, 2, 1'b1);
    send("c_5",   4'd5,    1234, 0, 0, 2, 1'b1);
    send("c_clr", KEY_CLR, 0,    0, 0, 1, 1'b1);

    // 300 * 300 wraps, then a digit starts a fresh calculation
    send("d_3a",  4'd3,    3,     0, 0, 2, 1'b1);
    send("d_0a",  4'd0,    30,    0, 0, 2, 1'b1);
    send("d_0b",  4'd0,    300,   0, 0, 2, 1'b1);
    send("d_mul", KEY_MUL, 300,   0, 0, 2, 1'b1);
    send("d_3b",  4'd3,    3,     0, 0, 2, 1'b1);
    send("d_0c",  4'd0,    30,    0, 0, 2, 1'b1);
    send("d_0d",  4'd0,    300,   0, 0, 2, 1'b1);
    send("d_eq",  KEY_EQ,  24464, 1, 0, 2, 1'b1);
    send("d_5",   4'd5,    5,     1, 0, 2, 1'b1);
    send("d_clr", KEY_CLR, 0,     0, 0, 1, 1'b1);

    // 100 / 7 through the divider, then divide by zero
    send("e_1",    4'd1,    1,     0, 0, 2,  1'b1);
    send("e_0a",   4'd0,    10,    0, 0, 2,  1'b1);
    send("e_0b",   4'd0,    100,   0, 0, 2,  1'b1);
    send("e_div",  KEY_DIV, 100,   0, 0, 2,  1'b1);
    send("e_7",    4'd7,    7,     0, 0, 2,  1'b1);
    send("e_eq",   KEY_EQ,  14,    0, 0, 18, 1'b1);
    send("e_div2", KEY_DIV, 14,    0, 0, 2,  1'b1);
    send("e_0c",   4'd0,    0,     0, 0, 2,  1'b1);
    send("e_eq2",  KEY_EQ,  65535, 0, 1, 2,  1'b1);

    // 9 / 3 = aborted by reset while the divider runs
    send("f_9",   4'd9,    9, 0, 1, 2, 1'b1);
    send("f_div", KEY_DIV, 9, 0, 1, 2, 1'b1);
    send("f_3",   4'd3,    3, 0, 1, 2, 1'b1);
    send("f_eq",  KEY_EQ,  0, 0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("divwait_busy", int'(busy), 1);
    check("divwait_key_ready", int'(key_ready), 0);
    rst_n = 1'b0;
    #1;
    check("abort_display", int'(display), 0);
    check("abort_key_ready", int'(key_ready), 0);
    check("abort_busy", int'(busy), 1);
    check("abort_ovf", int'(ovf), 0);
    check("abort_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("abort_release", 0, 0, 0, 1, cyc);

    // operator after operator replaces the pending op: 5 * + 3 = gives 8
    send("g_5",    4'd5,     5, 0, 0, 2, 1'b1);
    send("g_mul",  KEY_MUL,  5, 0, 0, 2, 1'b1);
    send("g_plus", KEY_PLUS, 5, 0, 0, 2, 1'b1);
    send("g_3",    4'd3,     3, 0, 0, 2, 1'b1);
    send("g_eq",   KEY_EQ,   8, 0, 0, 2, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding responses, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
